// File: rtl/dma_xfer_counter_if.sv
// Handshake and status bundle between the CPU/DMAC side and the transfer-length counter.
// The slave modport is the counter's view; the master modport is the driver's view.
interface dma_xfer_counter_if #(
   parameter int unsigned CW = 24
);
   logic          LOAD;
   logic [CW-1:0] LOAD_DATA;
   logic          DMAENA;
   logic          XFER;
   logic [1:0]    XSIZE;
   logic          FIFOEMPTY;
   logic          INT_ACK;
   logic [CW-1:0] COUNT;
   logic          ACTIVE;
   logic          DREQ_MASK;
   logic          TC;
   logic          TC_INT;
   logic          UNDERRUN;

   modport slave (
      input  LOAD, LOAD_DATA, DMAENA, XFER, XSIZE, FIFOEMPTY, INT_ACK,
      output COUNT, ACTIVE, DREQ_MASK, TC, TC_INT, UNDERRUN
   );

   modport master (
      output LOAD, LOAD_DATA, DMAENA, XFER, XSIZE, FIFOEMPTY, INT_ACK,
      input  COUNT, ACTIVE, DREQ_MASK, TC, TC_INT, UNDERRUN
   );
endinterface

// File: rtl/dma_xfer_counter.sv
// Transfer-length counter gating DREQ: counts bytes down per beat, masks DREQ at
// terminal count, waits for the FIFO to drain, then raises a sticky TC interrupt.
module dma_xfer_counter #(
   parameter int unsigned CW        = 24,
   parameter bit          LONG_ONLY = 1'b0
) (
   input logic               CLK,
   input logic               RST,
   dma_xfer_counter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] count_q;
   logic          active_q;
   logic          mask_q;
   logic          tc_q;
   logic          int_q;
   logic          under_q;
   logic [CW-1:0] dec;
   logic          load_nz;

   always_comb begin
      dec = '0;
      if (LONG_ONLY) begin
         dec = CW'(4);
      end else begin
         case (bus.XSIZE)
            2'b00:   dec = CW'(1);
            2'b01:   dec = CW'(2);
            default: dec = CW'(4);
         endcase
      end
   end

   assign load_nz = (bus.LOAD_DATA != '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         count_q  <= '0;
         active_q <= 1'b0;
         mask_q   <= 1'b1;
         tc_q     <= 1'b0;
         int_q    <= 1'b0;
         under_q  <= 1'b0;
      end else begin
         // Acknowledge first so a set on the same edge (DRAIN -> DONE) overrides it.
         if (bus.INT_ACK) begin
            int_q <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (bus.LOAD) begin
                  count_q <= bus.LOAD_DATA;
                  under_q <= 1'b0;
                  state   <= load_nz ? S_ARMED : S_IDLE;
               end
            end

            S_ARMED: begin
               if (bus.LOAD) begin
                  count_q <= bus.LOAD_DATA;
                  if (!load_nz) begin
                     state <= S_IDLE;
                  end
               end else if (bus.DMAENA) begin
                  state    <= S_RUN;
                  active_q <= 1'b1;
                  mask_q   <= 1'b0;
               end
            end

            S_RUN: begin
               if (bus.XFER) begin
                  if (dec < count_q) begin
                     count_q <= count_q - dec;
                     if (!bus.DMAENA) begin
                        state    <= S_IDLE;
                        active_q <= 1'b0;
                        mask_q   <= 1'b1;
                     end
                  end else begin
                     // Final beat: saturate at zero and mask before any further DREQ.
                     count_q <= '0;
                     mask_q  <= 1'b1;
                     state   <= S_DRAIN;
                     if (dec > count_q) begin
                        under_q <= 1'b1;
                     end
                  end
               end else if (!bus.DMAENA) begin
                  state    <= S_IDLE;
                  active_q <= 1'b0;
                  mask_q   <= 1'b1;
               end
            end

            S_DRAIN: begin
               if (bus.XFER) begin
                  under_q <= 1'b1;
               end
               if (!bus.DMAENA) begin
                  state    <= S_IDLE;
                  active_q <= 1'b0;
               end else if (bus.FIFOEMPTY) begin
                  state    <= S_DONE;
                  active_q <= 1'b0;
                  tc_q     <= 1'b1;
                  int_q    <= 1'b1;
               end
            end

            S_DONE: begin
               if (bus.XFER) begin
                  under_q <= 1'b1;
               end
               // A reload restarts like IDLE and wins over a same-cycle stray beat.
               if (bus.LOAD) begin
                  count_q <= bus.LOAD_DATA;
                  under_q <= 1'b0;
                  tc_q    <= 1'b0;
                  state   <= load_nz ? S_ARMED : S_IDLE;
               end else if (!bus.DMAENA) begin
                  state <= S_IDLE;
                  tc_q  <= 1'b0;
               end
            end

            default: begin
               state    <= S_IDLE;
               active_q <= 1'b0;
               mask_q   <= 1'b1;
               tc_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.COUNT     = count_q;
   assign bus.ACTIVE    = active_q;
   assign bus.DREQ_MASK = mask_q;
   assign bus.TC        = tc_q;
   assign bus.TC_INT    = int_q;
   assign bus.UNDERRUN  = under_q;

endmodule

// File: tb/tb_dma_xfer_counter.sv
// Scoreboard bench for dma_xfer_counter: each scenario is a table of per-cycle inputs
// and the outputs expected after the following clock edge.
module tb_dma_xfer_counter;

   localparam int unsigned CW = 24;

   typedef struct {
      logic          rs;
      logic          ld;
      logic [CW-1:0] d;
      logic          en;
      logic          xf;
      logic [1:0]    xs;
      logic          fe;
      logic          ak;
      logic [CW+4:0] exp;
   } row_t;

   logic clk;
   logic rst;
   int   tests;
   int   failed;
   logic [CW+4:0] sb[$];

   dma_xfer_counter_if #(.CW(CW)) bus ();

   dma_xfer_counter #(.CW(CW), .LONG_ONLY(1'b0)) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic row_t R(input logic rs, input logic ld, input logic [CW-1:0] d,
                              input logic en, input logic xf, input logic [1:0] xs,
                              input logic fe, input logic ak, input logic [CW-1:0] c,
                              input logic a, input logic m, input logic t,
                              input logic ti, input logic u);
      row_t r;
      r.rs = rs; r.ld = ld; r.d = d; r.en = en; r.xf = xf; r.xs = xs; r.fe = fe; r.ak = ak;
      r.exp = {c, a, m, t, ti, u};
      return r;
   endfunction

   function automatic logic [CW+4:0] snap();
      return {bus.COUNT, bus.ACTIVE, bus.DREQ_MASK, bus.TC, bus.TC_INT, bus.UNDERRUN};
   endfunction

   task automatic apply(input row_t r);
      rst           = r.rs;
      bus.LOAD      = r.ld;
      bus.LOAD_DATA = r.d;
      bus.DMAENA    = r.en;
      bus.XFER      = r.xf;
      bus.XSIZE     = r.xs;
      bus.FIFOEMPTY = r.fe;
      bus.INT_ACK   = r.ak;
   endtask

   task automatic test_reset();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(1,0,0,0,0,0,0,0, 0,0,1,0,0,0));
      rows.push_back(R(1,1,24'h55,1,1,2,1,0, 0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL reset[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_long_countdown();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h10,1,0,0,1,0, 24'h10,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h10,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,1,0, 24'hC,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,1,0, 24'h8,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,1,0, 24'h4,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,1,0, 24'h0,1,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h0,0,1,1,1,0));
      rows.push_back(R(0,0,0,0,0,0,1,1, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL long_countdown[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_mixed_underrun();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h5,1,0,0,0,0, 24'h5,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h5,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,1,0,0, 24'h3,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,0,0, 24'h0,1,1,0,0,1));
      rows.push_back(R(0,0,0,1,1,0,0,0, 24'h0,1,1,0,0,1));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h0,0,1,1,1,1));
      rows.push_back(R(0,0,0,1,1,0,1,0, 24'h0,0,1,1,1,1));
      rows.push_back(R(0,1,24'h0,1,0,0,1,0, 24'h0,0,1,0,1,0));
      rows.push_back(R(0,0,0,0,0,0,1,1, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL mixed_underrun[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_drain_wait();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h8,1,0,0,0,0, 24'h8,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h8,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,0,0, 24'h4,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,0,0, 24'h0,1,1,0,0,0));
      for (int k = 0; k < 10; k++) rows.push_back(R(0,0,0,1,0,0,0,0, 24'h0,1,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h0,0,1,1,1,0));
      rows.push_back(R(0,0,0,0,0,0,1,0, 24'h0,0,1,0,1,0));
      rows.push_back(R(0,0,0,0,0,0,1,1, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL drain_wait[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_abort();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h100,1,0,0,0,0, 24'h100,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h100,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,0,0, 24'hFC,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,0,0, 24'hF8,1,0,0,0,0));
      rows.push_back(R(0,0,0,0,0,0,0,0, 24'hF8,0,1,0,0,0));
      rows.push_back(R(0,0,0,0,0,0,0,0, 24'hF8,0,1,0,0,0));
      // beat together with disable: decrement applied, then abort
      rows.push_back(R(0,1,24'h10,0,0,0,0,0, 24'h10,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h10,1,0,0,0,0));
      rows.push_back(R(0,0,0,0,1,2,0,0, 24'hC,0,1,0,0,0));
      // final beat together with disable still drains, then the disable aborts the drain
      rows.push_back(R(0,1,24'h4,0,0,0,0,0, 24'h4,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h4,1,0,0,0,0));
      rows.push_back(R(0,0,0,0,1,2,0,0, 24'h0,1,1,0,0,0));
      rows.push_back(R(0,0,0,0,0,0,0,0, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL abort[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_int_handshake();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h2,1,0,0,1,0, 24'h2,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h2,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,1,1,0, 24'h0,1,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,1, 24'h0,0,1,1,1,0));
      rows.push_back(R(0,0,0,1,0,0,1,1, 24'h0,0,1,1,0,0));
      rows.push_back(R(0,1,24'h3,1,0,0,1,0, 24'h3,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h3,1,0,0,0,0));
      rows.push_back(R(0,0,0,0,0,0,1,0, 24'h3,0,1,0,0,0));
      rows.push_back(R(0,1,24'h0,1,0,0,1,0, 24'h0,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h0,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,1,2,1,0, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL int_handshake[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      row_t rows[$];
      logic [CW+4:0] got, want;
      rows.push_back(R(0,1,24'h40,1,0,0,0,0, 24'h40,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h40,1,0,0,0,0));
      rows.push_back(R(1,0,0,1,1,2,0,0, 24'h0,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,0,0, 24'h0,0,1,0,0,0));
      // reset out of DONE with sticky flags set
      rows.push_back(R(0,1,24'h1,1,0,0,1,0, 24'h1,0,1,0,0,0));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h1,1,0,0,0,0));
      rows.push_back(R(0,0,0,1,1,1,1,0, 24'h0,1,1,0,0,1));
      rows.push_back(R(0,0,0,1,0,0,1,0, 24'h0,0,1,1,1,1));
      rows.push_back(R(1,0,0,1,1,0,1,0, 24'h0,0,1,0,0,0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = snap(); want = sb.pop_front(); tests++;
         if (got !== want) begin
            failed++;
            $display("FAIL reset_mid[%0d]: got {cnt,act,mask,tc,int,ur}=%h required %h", i, got, want);
         end
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      apply(R(1,0,0,0,0,0,0,0, 0,0,1,0,0,0));
      #2;
      test_reset();
      test_long_countdown();
      test_mixed_underrun();
      test_drain_wait();
      test_abort();
      test_int_handshake();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/dma_xfer_counter.md
Name: dma_xfer_counter

Overview:
Transfer-length counter that sits directly upstream of the DMAC core's DREQ gating.
- Loaded by the CPU with a byte count.
- Decremented on every completed peripheral-side transfer beat.
- At terminal count it masks further DREQ, waits for the FIFO to drain, then raises a terminal-count interrupt for the register block to merge into INT.
- The core's DREQ_ term becomes (~DMAENA | _DREQ | DREQ_MASK).

Parameters:
CW, 24, width of the byte-count register.
LONG_ONLY, 0, when 1 every beat decrements by 4 regardless of XSIZE.

Ports:
CLK  input  1  system clock (SCLK domain); all logic on posedge.
RST  input  1  synchronous active-high reset.
LOAD  input  1  single-cycle strobe, CPU write to the count register.
LOAD_DATA  input  CW  byte count to load.
DMAENA  input  1  DMA enable from the control register.
XFER  input  1  single-cycle strobe, one beat completed (INCFIFO/DECFIFO pulse).
XSIZE  input  2  beat size: 00 byte, 01 word, 10 long, 11 treated as long.
FIFOEMPTY  input  1  FIFO empty flag.
INT_ACK  input  1  single-cycle strobe, CPU clear of the TC interrupt.
COUNT  output  CW  remaining byte count; readable by the CPU.
ACTIVE  output  1  high in RUN or DRAIN.
DREQ_MASK  output  1  high blocks peripheral DREQ.
TC  output  1  high in DONE.
TC_INT  output  1  sticky terminal-count interrupt.
UNDERRUN  output  1  sticky error: a beat exceeded the remaining count, or a beat arrived after TC.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE;
  - COUNT 0;
  - ACTIVE 0;
  - DREQ_MASK 1;
  - TC 0;
  - TC_INT 0;
  - UNDERRUN 0.
- RST has priority over every other input. RST in any state returns all outputs to their reset values on the next edge.
- Decrement amount D: 1, 2 or 4 from XSIZE; always 4 if LONG_ONLY=1.
- States:
  - IDLE
    - LOAD: COUNT<=LOAD_DATA and UNDERRUN<=0. Go to ARMED if LOAD_DATA!=0; otherwise stay in IDLE.
    - DREQ_MASK=1.
  - ARMED
    - LOAD reloads COUNT; LOAD_DATA=0 returns to IDLE.
    - DMAENA=1 goes to RUN; DREQ_MASK<=0 on the same edge.
  - RUN
    - XFER with D<COUNT: COUNT<=COUNT-D.
    - XFER with D>=COUNT: COUNT<=0, DREQ_MASK<=1, go to DRAIN. UNDERRUN<=1 if D>COUNT.
    - DMAENA=0 without XFER: abort. Go to IDLE, COUNT held, DREQ_MASK<=1, no TC_INT.
    - DMAENA=0 together with XFER: the decrement is applied first, then abort, unless the beat reaches 0, in which case go to DRAIN.
    - LOAD is ignored.
  - DRAIN
    - FIFOEMPTY=1: go to DONE, TC<=1, TC_INT<=1.
    - XFER: UNDERRUN<=1, COUNT unchanged.
    - DMAENA=0: go to IDLE, no TC_INT.
  - DONE
    - TC=1, DREQ_MASK=1.
    - XFER: UNDERRUN<=1.
    - LOAD: behaves as in IDLE and clears TC. TC_INT is unaffected.
    - DMAENA=0 alone: go to IDLE, TC<=0.
- Latency:
  - COUNT reflects an XFER on the edge after the strobe.
  - DREQ_MASK rises on that same edge. Zero beats are admitted after the final one; the core sees the mask one cycle after the last XFER.
- TC_INT clearing:
  - INT_ACK clears TC_INT.
  - If INT_ACK arrives on the same edge that sets TC_INT, the set wins.
- Arithmetic:
  - Unsigned CW-bit arithmetic.
  - COUNT never wraps; it saturates at 0.
- ACTIVE = state in {RUN, DRAIN}, registered alongside the state.

Test Plan:
- Long-beat countdown: LOAD 0x000010, DMAENA=1, four XFER with XSIZE=10, FIFOEMPTY=1 → COUNT steps 0xC, 0x8, 0x4, 0x0. DREQ_MASK=1 the cycle after the 4th XFER. TC and TC_INT are 1 one cycle later. UNDERRUN=0.
- Mixed sizes with underrun: LOAD 5, then XFER word, long, byte → COUNT 3, then 0. UNDERRUN=1 after the long beat. The byte beat in DRAIN/DONE leaves COUNT at 0.
- Drain wait: count reaches 0 with FIFOEMPTY=0 for 10 cycles → TC stays 0 and DREQ_MASK stays 1. TC_INT rises exactly 1 cycle after FIFOEMPTY goes high.
- Abort: LOAD 0x100, RUN, two long XFER, then DMAENA=0 → IDLE, COUNT=0xF8, TC_INT=0, DREQ_MASK=1.
- Interrupt handshake and zero load:
  - INT_ACK in the same cycle as the TC_INT set edge → TC_INT=1.
  - INT_ACK one cycle later → TC_INT=0.
  - LOAD 0 → stays IDLE and DREQ_MASK stays 1 even with DMAENA=1.
- Reset mid-operation: RST asserted in RUN with COUNT=0x40 → next edge COUNT=0, DREQ_MASK=1, all other outputs 0. XFER during RST is ignored.
